// File: rtl/tdm_demux.sv
// tdm_demux: receive-side TDM frame demultiplexer.
// Locks to a frame-sync strobe and steers each serial slot of a frame
// to its channel bit. Presents every complete frame as a parallel word
// with a one-cycle valid pulse.
//
// Optional feature: define TDM_DEMUX_PARITY_EN to add a trailing even-parity
// slot to each frame. A frame that fails parity is dropped and parity_err
// pulses.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   en           slot strobe; din/fsync sampled only when high
//   din          serial TDM data
//   fsync        frame sync, high together with the slot-0 bit
//   ch_out       last complete frame, bit k = slot k
//   frame_valid  one-cycle pulse when ch_out updates
//   locked       high while locked to the frame boundary
//   sync_err     one-cycle pulse on fsync at a non-zero slot
//   parity_err   one-cycle pulse on bad frame parity (0 without the feature)
module tdm_demux #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                din,
  input  logic                fsync,
  output logic [CHANNELS-1:0] ch_out,
  output logic                frame_valid,
  output logic                locked,
  output logic                sync_err,
  output logic                parity_err
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int unsigned FLEN = CHANNELS + 1;
`else
  localparam int unsigned FLEN = CHANNELS;
`endif
  localparam int unsigned SLOT_W = $clog2(FLEN);
  localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FLEN - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(MISS_LIMIT);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t              state, state_n;
  logic [SLOT_W-1:0]   slot, slot_n;
  logic [MISS_W-1:0]   miss, miss_n, miss_inc;
  logic [FLEN-1:0]     acc, acc_n;
  logic [FLEN-1:0]     frame_c;
  logic [CHANNELS-1:0] ch_out_n;
  logic                frame_valid_n;
  logic                sync_err_n;
  logic                parity_err_n;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      slot        <= '0;
      miss        <= '0;
      acc         <= '0;
      ch_out      <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_n;
      slot        <= slot_n;
      miss        <= miss_n;
      acc         <= acc_n;
      ch_out      <= ch_out_n;
      frame_valid <= frame_valid_n;
      locked      <= (state_n == LOCKED);
      sync_err    <= sync_err_n;
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic parity_err_q;

  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_err_n;
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // Next-state, slot steering and frame completion
  always_comb begin
    state_n       = state;
    slot_n        = slot;
    miss_n        = miss;
    acc_n         = acc;
    ch_out_n      = ch_out;
    frame_valid_n = 1'b0;
    sync_err_n    = 1'b0;
    parity_err_n  = 1'b0;
    miss_inc      = miss + MISS_W'(1);
    frame_c       = acc;
    frame_c[slot] = din;

    if (en) begin
      case (state)
        HUNT: begin
          if (fsync) begin
            state_n = LOCKED;
            slot_n  = SLOT_ONE;
            miss_n  = '0;
            acc_n   = FLEN'(din);
          end
        end
        LOCKED: begin
          if (fsync) begin
            // fsync wins over everything; off-slot fsync realigns and drops the partial frame
            sync_err_n = (slot != '0);
            slot_n     = SLOT_ONE;
            miss_n     = '0;
            acc_n      = FLEN'(din);
          end else if (slot == '0) begin
            // Missing sync: flywheel until MISS_LIMIT consecutive misses
            miss_n = miss_inc;
            if (miss_inc == MISS_MAX) begin
              state_n = HUNT;
              slot_n  = '0;
              acc_n   = '0;
            end else begin
              slot_n = SLOT_ONE;
              acc_n  = FLEN'(din);
            end
          end else if (slot == LAST_SLOT) begin
            slot_n = '0;
            acc_n  = frame_c;
`ifdef TDM_DEMUX_PARITY_EN
            // Even parity over data plus parity slot must XOR to zero
            if (^frame_c) begin
              parity_err_n = 1'b1;
            end else begin
              frame_valid_n = 1'b1;
              ch_out_n      = frame_c[CHANNELS-1:0];
            end
`else
            frame_valid_n = 1'b1;
            ch_out_n      = frame_c;
`endif
          end else begin
            acc_n  = frame_c;
            slot_n = slot + SLOT_ONE;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed bench for tdm_demux (CHANNELS=4, MISS_LIMIT=2).
// Covers reset, lock, en gaps, misalignment, lock loss, mid-frame reset,
// and parity checking when TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux;

  logic       clk;
  logic       rst;
  logic       en;
  logic       din;
  logic       fsync;
  logic [3:0] ch_out;
  logic       frame_valid;
  logic       locked;
  logic       sync_err;
  logic       parity_err;

  int vectors     = 0;
  int miscompares = 0;

  tdm_demux #(
    .CHANNELS   (4),
    .MISS_LIMIT (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .din         (din),
    .fsync       (fsync),
    .ch_out      (ch_out),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge
  task automatic cyc(input logic e, input logic d, input logic f);
    en    = e;
    din   = d;
    fsync = f;
    @(posedge clk);
    #1;
  endtask

  // Trailing parity slot of a frame with data d (no-op without the feature)
  task automatic tail(input logic [3:0] d);
`ifdef TDM_DEMUX_PARITY_EN
    cyc(1'b1, ^d, 1'b0);
`else
    en = 1'b1;
    if (d == 4'hx) en = 1'b1;
`endif
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] co, input logic fv,
                          input logic lk, input logic se, input logic pe);
    chk({tag, ".ch_out"},      32'(ch_out),      32'(co));
    chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(fv));
    chk({tag, ".locked"},      32'(locked),      32'(lk));
    chk({tag, ".sync_err"},    32'(sync_err),    32'(se));
    chk({tag, ".parity_err"},  32'(parity_err),  32'(pe));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; din = 1'b0; fsync = 1'b0;
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    chk_outs("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // HUNT discards data without fsync
    cyc(1'b1, 1'b1, 1'b0);
    chk_outs("hunt_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Lock: 1,0,1,1 -> 4'b1101
    cyc(1'b1, 1'b1, 1'b1);
    chk_outs("lock_s0", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    tail(4'b1101);
    chk_outs("lock_frame", 4'b1101, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk_outs("lock_hold", 4'b1101, 1'b0, 1'b1, 1'b0, 1'b0);

    // Misalignment: fsync at slot 2, then realigned frame 0,1,1,0 -> 4'b0110
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    chk_outs("misalign", 4'b1101, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk_outs("misalign_s1", 4'b1101, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    tail(4'b0110);
    chk_outs("realign_frame", 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0);

    // en gaps: 1,0,1,1 with idle cycles (fsync during a gap is ignored)
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk_outs("gap_a", 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk_outs("gap_b", 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    tail(4'b1101);
    chk_outs("gap_frame", 4'b1101, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk_outs("gap_hold", 4'b1101, 1'b0, 1'b1, 1'b0, 1'b0);

    // Lock loss: first miss flywheels (0,1,1,1 -> 4'b1110), second drops lock
    cyc(1'b1, 1'b0, 1'b0);
    chk_outs("miss1", 4'b1101, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    tail(4'b1110);
    chk_outs("miss1_frame", 4'b1110, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk_outs("miss2", 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk_outs("miss2_hunt", 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0);

    // Relock, then reset at slot 2 with en low
    cyc(1'b1, 1'b1, 1'b1);
    chk_outs("relock", 4'b1110, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    chk_outs("mid_reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk_outs("post_reset_hunt", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fresh frame 0,0,1,1 -> 4'b1100
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    tail(4'b1100);
    chk_outs("fresh_frame", 4'b1100, 1'b1, 1'b1, 1'b0, 1'b0);

`ifdef TDM_DEMUX_PARITY_EN
    // Good parity: 1,1,0,1 + parity 1 -> 4'b1011
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk_outs("par_good", 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
    // Bad parity: same data with parity 0
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk_outs("par_bad", 4'b1011, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk_outs("par_after", 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
